oser10_word_sched: RTL and testbench
====================================

Name: oser10_word_sched

Overview:
- PCLK-domain controller that sequences one 10:1 DDR output serializer (OSER10, ports RESET/PCLK/FCLK/D0..D9/Q).
- Drives the serializer's RESET during start-up, then sends a training pattern, then streams user words from a valid/ready source.
- Inserts idle words on underrun and applies a programmable bit rotation (bitslip) for word alignment at the far end.
- Sits between the link framing logic and the serializer. D0 is the first bit out on Q.

Parameters:
HOLD_CYCLES, 8, PCLK cycles SER_RESET is held high after reset release (range 1..255)
TRAIN_LEN, 64, training words sent per training burst (range 1..65535)
TRAIN_WORD, 10'b1111100000, training pattern word
IDLE_WORD, 10'b1101010100, word sent when no user data is valid

Ports:
PCLK  in  1  parallel clock, rising edge; same clock as serializer PCLK
RESETN  in  1  synchronous active-low reset, sampled on PCLK rising edge
SER_RESET  out  1  to serializer RESET, active high
SER_D  out  10  to serializer D9..D0, with SER_D[0] driving D0
IN_DATA  in  10  user word, IN_DATA[0] is first bit on the wire
IN_VALID  in  1  IN_DATA is valid
IN_READY  out  1  block accepts IN_DATA this cycle
TRAIN_REQ  in  1  single-cycle request to (re)start a training burst
SLIP  in  1  single-cycle request to advance rotation by one bit
SLIP_AMT  out  4  current rotation, 0..9
TRAIN_DONE  out  1  one-cycle pulse when a training burst completes
UNDERRUN  out  1  one-cycle pulse for each idle word inserted in DATA state
STATE  out  2  0=HOLD, 1=TRAIN, 2=DATA

Behaviour:
- Reset: RESETN is synchronous, active low, one clock, PCLK. Reset is sampled low on a PCLK rising edge. After that edge:
  - STATE=HOLD, hold counter=HOLD_CYCLES-1, SER_RESET=1.
  - SER_D=0, IN_READY=0, SLIP_AMT=0, TRAIN_DONE=0, UNDERRUN=0, train counter=0.
  - Reset mid-operation aborts immediately; no partial word, pulse or handshake survives.
- All outputs are registered. The only exception is IN_READY, which is decoded from the state register (IN_READY = STATE==DATA).
- Rotation function rot(w): SER_D[i] = w[(i+SLIP_AMT) mod 10]. SLIP_AMT=0 means identity.
- HOLD state:
  - SER_RESET=1, SER_D=0.
  - The hold counter decrements each cycle.
  - In the cycle the counter is 0, the next state is TRAIN. SER_RESET is 0 from the first TRAIN cycle.
  - TRAIN_REQ and SLIP are ignored.
- TRAIN state:
  - Every cycle, SER_D <= rot(TRAIN_WORD) and the train counter increments.
  - When the counter reaches TRAIN_LEN-1:
    - next state is DATA;
    - counter clears;
    - TRAIN_DONE pulses in the first DATA cycle.
  - TRAIN_REQ during TRAIN restarts the counter at 0 and stays in TRAIN; no TRAIN_DONE pulse is issued for the aborted burst.
- DATA state:
  - IN_READY=1. A transfer occurs when IN_VALID && IN_READY.
  - On a transfer: SER_D <= rot(IN_DATA) at the next PCLK edge, i.e. 1-cycle latency from acceptance to SER_D.
  - When IN_VALID=0: SER_D <= rot(IDLE_WORD), and UNDERRUN=1 on that same registered cycle.
  - TRAIN_REQ in DATA: the word offered in that cycle is still accepted. The next state is TRAIN, and IN_READY=0 from the next cycle.
- SLIP:
  - Honoured in TRAIN and DATA.
  - SLIP_AMT <= (SLIP_AMT==9) ? 0 : SLIP_AMT+1.
  - The new value applies to the word registered at the following edge, not the word registered in the same cycle as SLIP.
  - SLIP and TRAIN_REQ in the same cycle: both take effect.
- Width rules:
  - Hold counter is 8 bits.
  - Train counter is 16 bits.
  - Comparisons use the parameter minus 1, evaluated at elaboration.
- STATE encoding 3 is unreachable. If ever seen it is treated as HOLD on the next edge.

Decomposition:
- Shared package oser10_pkg:
  - state enum (HOLD/TRAIN/DATA);
  - default TRAIN_WORD and IDLE_WORD constants;
  - 10-bit word typedef;
  - rot10 function (word, amount).
- One sub-module, oser10_rot10: a registered 10-bit barrel rotator (word, amount in; rotated word out).
- The FSM, counters and handshake stay in the top.

Test Plan:
- Reset release, HOLD_CYCLES=8, TRAIN_LEN=4: RESETN low 3 cycles then high.
  - SER_RESET=1 for exactly 8 cycles after release.
  - Then SER_D=10'b1111100000 for 4 cycles, with SER_RESET=0.
  - STATE=2 and TRAIN_DONE=1 for one cycle, then IN_READY=1.
- DATA streaming: IN_VALID=1 with words 10'h001, 10'h155, 10'h3FF on consecutive cycles.
  - SER_D shows the same values one cycle later.
  - UNDERRUN stays 0 throughout.
- Underrun: IN_VALID low for 2 cycles in DATA.
  - SER_D=10'b1101010100 twice.
  - UNDERRUN high exactly 2 cycles.
- Bitslip: 10 SLIP pulses with IN_DATA=10'h001.
  - SLIP_AMT steps 1..9 then 0.
  - With SLIP_AMT=3, SER_D=10'b0010000000 (bit 0 maps to position 7).
- Retrain: TRAIN_REQ while IN_VALID=1 with IN_DATA=10'h2AA.
  - 10'h2AA is transmitted.
  - The next cycle has STATE=1 and IN_READY=0.
  - A second TRAIN_REQ mid-burst extends TRAIN to TRAIN_LEN words after it, with no TRAIN_DONE for the aborted burst.
- Reset mid-DATA with SLIP_AMT=5: RESETN low 1 cycle.
  - SER_RESET=1, SER_D=0, SLIP_AMT=0, STATE=0 after that edge.
  - Full HOLD→TRAIN sequence repeats.

Source files
------------

// File: rtl/oser10_pkg.sv
// Shared types and helpers for the OSER10 word scheduler.
//   word_t    : 10-bit serializer word, bit 0 is first on the wire
//   state_t   : scheduler state (HOLD/TRAIN/DATA), encoding visible on STATE
//   rot10()   : out[i] = w[(i + amount) mod 10]
package oser10_pkg;

  typedef logic [9:0] word_t;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_TRAIN = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  localparam word_t TRAIN_WORD_DEFAULT = 10'b1111100000;
  localparam word_t IDLE_WORD_DEFAULT  = 10'b1101010100;

  // Amounts above 9 never occur in use, but still fold back into 0..9.
  function automatic word_t rot10(input word_t w, input logic [3:0] amount);
    word_t      r;
    logic [4:0] sum;
    logic [3:0] idx;
    for (int unsigned i = 0; i < 10; i++) begin
      sum = 5'(i) + {1'b0, amount};
      if (sum >= 5'd20)
        sum = sum - 5'd20;
      else if (sum >= 5'd10)
        sum = sum - 5'd10;
      idx  = sum[3:0];
      r[i] = w[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/oser10_rot10.sv
// Registered 10-bit barrel rotator.
//   clk, rst_n : clock and synchronous active-low reset (clears output)
//   word       : word to rotate
//   amount     : rotation, 0..9
//   rotated    : registered rot10(word, amount)
module oser10_rot10
  import oser10_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  word_t      word,
  input  logic [3:0] amount,
  output word_t      rotated
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      rotated <= '0;
    else
      rotated <= rot10(word, amount);
  end

endmodule

// File: rtl/oser10_word_sched.sv
// PCLK-domain sequencer for one OSER10 10:1 serializer: holds the serializer
// in reset, sends a training burst, then streams user words with idle-word
// fill on underrun and a programmable bitslip rotation.
//   PCLK, RESETN : clock, synchronous active-low reset
//   SER_RESET    : serializer RESET (active high)
//   SER_D        : serializer D9..D0, SER_D[0] -> D0 (first bit out)
//   IN_DATA/IN_VALID/IN_READY : user word source handshake
//   TRAIN_REQ    : pulse to (re)start a training burst
//   SLIP         : pulse to advance rotation by one bit
//   SLIP_AMT     : current rotation 0..9
//   TRAIN_DONE   : pulse in the first DATA cycle after a completed burst
//   UNDERRUN     : pulse per idle word inserted in DATA
//   STATE        : 0=HOLD, 1=TRAIN, 2=DATA
module oser10_word_sched
  import oser10_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned TRAIN_LEN   = 64,
  parameter word_t       TRAIN_WORD  = TRAIN_WORD_DEFAULT,
  parameter word_t       IDLE_WORD   = IDLE_WORD_DEFAULT
) (
  input  logic       PCLK,
  input  logic       RESETN,
  output logic       SER_RESET,
  output logic [9:0] SER_D,
  input  logic [9:0] IN_DATA,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       TRAIN_REQ,
  input  logic       SLIP,
  output logic [3:0] SLIP_AMT,
  output logic       TRAIN_DONE,
  output logic       UNDERRUN,
  output logic [1:0] STATE
);

  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [15:0] train_cnt;
  logic [3:0]  slip_amt;
  logic [3:0]  slip_next;
  logic        ser_reset;
  logic        train_done;
  logic        underrun;
  word_t       next_word;

  // Word handed to the rotator; it is registered with the current slip_amt,
  // so a SLIP only affects words registered after the one it arrives with.
  always_comb begin
    next_word = '0;
    case (state)
      S_TRAIN: next_word = TRAIN_WORD;
      S_DATA:  next_word = IN_VALID ? IN_DATA : IDLE_WORD;
      default: next_word = '0;
    endcase
  end

  always_comb begin
    slip_next = (slip_amt == 4'd9) ? '0 : slip_amt + 4'd1;
  end

  oser10_rot10 u_rot (
    .clk     (PCLK),
    .rst_n   (RESETN),
    .word    (next_word),
    .amount  (slip_amt),
    .rotated (SER_D)
  );

  always_ff @(posedge PCLK) begin
    if (!RESETN) begin
      state      <= S_HOLD;
      hold_cnt   <= HOLD_LAST;
      train_cnt  <= '0;
      slip_amt   <= '0;
      ser_reset  <= 1'b1;
      train_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      train_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        S_HOLD: begin
          if (hold_cnt == 8'd0) begin
            state     <= S_TRAIN;
            ser_reset <= 1'b0;
            train_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        S_TRAIN: begin
          // A restart takes priority over completion: the aborted burst
          // never reports TRAIN_DONE.
          if (TRAIN_REQ) begin
            train_cnt <= '0;
          end else if (train_cnt == TRAIN_LAST) begin
            train_cnt  <= '0;
            state      <= S_DATA;
            train_done <= 1'b1;
          end else begin
            train_cnt <= train_cnt + 16'd1;
          end
          if (SLIP)
            slip_amt <= slip_next;
        end
        S_DATA: begin
          underrun <= !IN_VALID;
          if (TRAIN_REQ) begin
            state     <= S_TRAIN;
            train_cnt <= '0;
          end
          if (SLIP)
            slip_amt <= slip_next;
        end
        default: begin
          // Unreachable encoding 3 falls back into a fresh HOLD.
          state     <= S_HOLD;
          hold_cnt  <= HOLD_LAST;
          ser_reset <= 1'b1;
        end
      endcase
    end
  end

  assign SER_RESET  = ser_reset;
  assign SLIP_AMT   = slip_amt;
  assign TRAIN_DONE = train_done;
  assign UNDERRUN   = underrun;
  assign STATE      = state;
  assign IN_READY   = (state == S_DATA);

endmodule

// File: tb/tb_oser10_word_sched.sv
// Bench for oser10_word_sched: directed table, hand-written corner
// sequences and a randomized run, all compared against a behavioural model.
module tb_oser10_word_sched;

  localparam int unsigned HOLD_N  = 8;
  localparam int unsigned TRAIN_N = 4;
  localparam logic [9:0]  TW      = 10'b1111100000;
  localparam logic [9:0]  IW      = 10'b1101010100;

  logic       PCLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       SER_RESET;
  logic [9:0] SER_D;
  logic [9:0] IN_DATA = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic       TRAIN_REQ = 1'b0;
  logic       SLIP = 1'b0;
  logic [3:0] SLIP_AMT;
  logic       TRAIN_DONE;
  logic       UNDERRUN;
  logic [1:0] STATE;

  oser10_word_sched #(
    .HOLD_CYCLES (HOLD_N),
    .TRAIN_LEN   (TRAIN_N)
  ) dut (
    .PCLK       (PCLK),
    .RESETN     (RESETN),
    .SER_RESET  (SER_RESET),
    .SER_D      (SER_D),
    .IN_DATA    (IN_DATA),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .TRAIN_REQ  (TRAIN_REQ),
    .SLIP       (SLIP),
    .SLIP_AMT   (SLIP_AMT),
    .TRAIN_DONE (TRAIN_DONE),
    .UNDERRUN   (UNDERRUN),
    .STATE      (STATE)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase number plus "cycles remaining" budgets.
  int         m_mode;
  int         m_hold_left;
  int         m_train_left;
  int         m_slip;
  logic [9:0] m_serd;
  logic       m_ser_reset;
  logic       m_done;
  logic       m_under;

  function automatic logic [9:0] rotr(input logic [9:0] w, input int s);
    logic [19:0] dbl;
    logic [4:0]  sh;
    dbl = {w, w};
    sh  = 5'(s);
    return dbl[sh +: 10];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [9:0] w;
    if (!RESETN) begin
      m_mode = 0; m_hold_left = HOLD_N; m_train_left = 0; m_slip = 0;
      m_serd = '0; m_ser_reset = 1'b1; m_done = 1'b0; m_under = 1'b0;
    end else begin
      case (m_mode)
        1:       w = TW;
        2:       w = IN_VALID ? IN_DATA : IW;
        default: w = '0;
      endcase
      m_serd  = rotr(w, m_slip);
      m_under = (m_mode == 2) && !IN_VALID;
      m_done  = 1'b0;
      if (m_mode != 0 && SLIP) m_slip = (m_slip + 1) % 10;
      if (m_mode == 0) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_mode = 1; m_train_left = TRAIN_N; m_ser_reset = 1'b0;
        end
      end else if (m_mode == 1) begin
        if (TRAIN_REQ) m_train_left = TRAIN_N;
        else begin
          m_train_left--;
          if (m_train_left == 0) begin m_mode = 2; m_done = 1'b1; end
        end
      end else if (TRAIN_REQ) begin
        m_mode = 1; m_train_left = TRAIN_N;
      end
    end
  endtask

  task automatic check_model();
    chk("m_ser_reset", SER_RESET, m_ser_reset);
    chk("m_ser_d", SER_D, m_serd);
    chk("m_in_ready", IN_READY, (m_mode == 2));
    chk("m_slip_amt", SLIP_AMT, m_slip);
    chk("m_train_done", TRAIN_DONE, m_done);
    chk("m_underrun", UNDERRUN, m_under);
    chk("m_state", STATE, m_mode);
  endtask

  task automatic cycle();
    @(posedge PCLK);
    model_step();
    #1;
    check_model();
  endtask

  // From just after a reset edge: count HOLD length, then watch the burst.
  task automatic hold_and_train();
    int hold_seen;
    RESETN = 1'b1; IN_VALID = 1'b0; SLIP = 1'b0; TRAIN_REQ = 1'b0;
    hold_seen = 1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (SER_RESET) hold_seen++;
      else break;
    end
    chk("hold_len", hold_seen, HOLD_N);
    chk("train_entry_state", STATE, 1);
    chk("train_entry_serd", SER_D, 0);
    for (int k = 0; k < TRAIN_N; k++) begin
      cycle();
      chk("train_serd", SER_D, TW);
      chk("train_ser_reset", SER_RESET, 0);
    end
    chk("data_state", STATE, 2);
    chk("train_done_pulse", TRAIN_DONE, 1);
    chk("data_ready", IN_READY, 1);
  endtask

  typedef struct packed {
    logic       v;
    logic [9:0] d;
    logic       slip;
    logic [9:0] e_serd;
    logic       e_under;
    logic [3:0] e_slip;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int n;
    logic early_done;

    vecs[0]  = '{1'b1, 10'h001, 1'b0, 10'h001, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 10'h155, 1'b0, 10'h155, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 10'h3FF, 1'b0, 10'h3FF, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 10'h0F0, 1'b0, IW,      1'b1, 4'd0};
    vecs[4]  = '{1'b0, 10'h00F, 1'b0, IW,      1'b1, 4'd0};
    vecs[5]  = '{1'b1, 10'h2AA, 1'b0, 10'h2AA, 1'b0, 4'd0};
    vecs[6]  = '{1'b1, 10'h001, 1'b1, 10'h001, 1'b0, 4'd1};
    vecs[7]  = '{1'b1, 10'h001, 1'b1, 10'h200, 1'b0, 4'd2};
    vecs[8]  = '{1'b1, 10'h001, 1'b1, 10'h100, 1'b0, 4'd3};
    vecs[9]  = '{1'b1, 10'h001, 1'b1, 10'h080, 1'b0, 4'd4};
    vecs[10] = '{1'b1, 10'h001, 1'b1, 10'h040, 1'b0, 4'd5};
    vecs[11] = '{1'b1, 10'h001, 1'b1, 10'h020, 1'b0, 4'd6};
    vecs[12] = '{1'b1, 10'h001, 1'b1, 10'h010, 1'b0, 4'd7};
    vecs[13] = '{1'b1, 10'h001, 1'b1, 10'h008, 1'b0, 4'd8};
    vecs[14] = '{1'b1, 10'h001, 1'b1, 10'h004, 1'b0, 4'd9};
    vecs[15] = '{1'b1, 10'h001, 1'b1, 10'h002, 1'b0, 4'd0};
    vecs[16] = '{1'b1, 10'h001, 1'b0, 10'h001, 1'b0, 4'd0};

    // Reset held for three cycles.
    RESETN = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chk("rst_state", STATE, 0);
    chk("rst_ser_reset", SER_RESET, 1);
    chk("rst_serd", SER_D, 0);
    chk("rst_slip", SLIP_AMT, 0);
    chk("rst_ready", IN_READY, 0);

    hold_and_train();

    // Streaming, underrun and bitslip vectors.
    for (int i = 0; i < 17; i++) begin
      IN_VALID = vecs[i].v; IN_DATA = vecs[i].d; SLIP = vecs[i].slip;
      cycle();
      chk($sformatf("vec%0d_serd", i), SER_D, vecs[i].e_serd);
      chk($sformatf("vec%0d_under", i), UNDERRUN, vecs[i].e_under);
      chk($sformatf("vec%0d_slip", i), SLIP_AMT, vecs[i].e_slip);
    end
    SLIP = 1'b0;

    // Retrain: the word offered with TRAIN_REQ still goes out.
    IN_VALID = 1'b1; IN_DATA = 10'h2AA; TRAIN_REQ = 1'b1;
    cycle();
    chk("retrain_serd", SER_D, 10'h2AA);
    chk("retrain_state", STATE, 1);
    chk("retrain_ready", IN_READY, 0);
    TRAIN_REQ = 1'b0; IN_VALID = 1'b0;
    cycle();
    cycle();
    TRAIN_REQ = 1'b1;
    cycle();
    TRAIN_REQ = 1'b0;
    n = 0; early_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n++;
      if (STATE == 2'd2) break;
      if (TRAIN_DONE) early_done = 1'b1;
    end
    chk("retrain_len", n, TRAIN_N);
    chk("retrain_no_early_done", early_done, 0);
    chk("retrain_done", TRAIN_DONE, 1);

    // Bring SLIP_AMT to 5, then reset mid-DATA.
    IN_VALID = 1'b1; IN_DATA = 10'h155; SLIP = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    SLIP = 1'b0;
    cycle();
    chk("slip5", SLIP_AMT, 5);
    RESETN = 1'b0;
    cycle();
    chk("mid_rst_ser_reset", SER_RESET, 1);
    chk("mid_rst_serd", SER_D, 0);
    chk("mid_rst_slip", SLIP_AMT, 0);
    chk("mid_rst_state", STATE, 0);
    chk("mid_rst_under", UNDERRUN, 0);
    hold_and_train();

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      RESETN    = ($urandom_range(0, 199) != 0);
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_DATA   = 10'($urandom);
      SLIP      = ($urandom_range(0, 9) == 0);
      TRAIN_REQ = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
